// File: rtl/pkg_sched.sv
// Packet scheduler: round-robin arbiter over four sources that frames each packet as a header plus PKT_LEN payload words.
// Optional word timeout enabled by defining PKG_SCHED_TIMEOUT_EN; without it sched_err is tied low.
`timescale 1ns/1ps

module pkg_sched #(
  parameter int PKT_LEN    = 8,
  parameter int TIMEOUT_US = 100
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic [5:0]  dev_id,
  input  logic [3:0]  chip_req,
  output logic [3:0]  chip_gnt,
  input  logic [15:0] chip_d,
  input  logic        chip_vld,
  output logic        chip_rdy,
  output logic [15:0] pkg_d,
  output logic        pkg_vld,
  input  logic        pkg_done,
  output logic        sched_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, WAIT_DONE} state_t;

  localparam logic [5:0] LEN = 6'(PKT_LEN);

  state_t     state, next_state;
  logic [5:0] word_cnt;
  logic [1:0] ch;
  logic [1:0] rr_ptr;
  logic [1:0] win_ch;
  logic       all_in;
  logic       accept;
  logic       timed_out;

  assign all_in   = (word_cnt == LEN);
  assign chip_rdy = (state == DATA) && !all_in && !timed_out;
  assign accept   = chip_vld && chip_rdy;

  // Scan downwards so the requester closest after rr_ptr is the last to overwrite win_ch.
  always_comb begin
    win_ch = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (chip_req[rr_ptr + 2'(i)]) win_ch = rr_ptr + 2'(i);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // DATA lingers one extra cycle after the last word so its pkg_vld pulse never lands in WAIT_DONE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (|chip_req) next_state = HDR;
      HDR:       next_state = DATA;
      DATA:      if (all_in) next_state = WAIT_DONE;
      WAIT_DONE: if (pkg_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      chip_gnt <= 4'b0000;
      pkg_d    <= 16'h0000;
      pkg_vld  <= 1'b0;
      word_cnt <= 6'd0;
      ch       <= 2'd0;
      rr_ptr   <= 2'd0;
    end else begin
      pkg_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (|chip_req) begin
            ch       <= win_ch;
            chip_gnt <= 4'b0001 << win_ch;
            pkg_d    <= {4'hA, dev_id, 4'h0, win_ch};
            pkg_vld  <= 1'b1;
            word_cnt <= 6'd0;
          end
        end
        DATA: begin
          if (timed_out && !all_in) begin
            pkg_d    <= 16'hFFFF;
            pkg_vld  <= 1'b1;
            word_cnt <= word_cnt + 6'd1;
          end else if (accept) begin
            pkg_d    <= chip_d;
            pkg_vld  <= 1'b1;
            word_cnt <= word_cnt + 6'd1;
          end
        end
        WAIT_DONE: begin
          if (pkg_done) begin
            chip_gnt <= 4'b0000;
            rr_ptr   <= ch + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PKG_SCHED_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       to_hit;

  // Only a pulse in a cycle that accepted no word can complete the timeout.
  assign to_hit = chip_rdy && !chip_vld && pluse_us && (to_cnt == 8'(TIMEOUT_US - 1));

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      to_cnt    <= 8'd0;
      timed_out <= 1'b0;
      sched_err <= 1'b0;
    end else begin
      if (state != DATA || accept)  to_cnt <= 8'd0;
      else if (chip_rdy && pluse_us) to_cnt <= to_cnt + 8'd1;

      if (state != DATA) timed_out <= 1'b0;
      else if (to_hit)   timed_out <= 1'b1;

      if (to_hit)       sched_err <= 1'b1;
      else if (err_clr) sched_err <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign timed_out  = 1'b0;
  assign sched_err  = 1'b0;
  assign unused_cfg = ^{pluse_us, err_clr};
`endif

endmodule

// File: tb/tb_pkg_sched.sv
// Randomised bench for pkg_sched: a queue-based packet model predicts grants, headers and payload streams.
`timescale 1ns/1ps

module tb_pkg_sched;

  localparam int PKT_LEN    = 8;
  localparam int TIMEOUT_US = 3;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        pluse_us;
  logic [5:0]  dev_id;
  logic [3:0]  chip_req;
  logic [3:0]  chip_gnt;
  logic [15:0] chip_d;
  logic        chip_vld;
  logic        chip_rdy;
  logic [15:0] pkg_d;
  logic        pkg_vld;
  logic        pkg_done;
  logic        sched_err;
  logic        err_clr;

  int          checks = 0;
  int          errors = 0;
  int          m_ptr  = 0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];

  pkg_sched #(.PKT_LEN(PKT_LEN), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .pluse_us (pluse_us),
    .dev_id   (dev_id),
    .chip_req (chip_req),
    .chip_gnt (chip_gnt),
    .chip_d   (chip_d),
    .chip_vld (chip_vld),
    .chip_rdy (chip_rdy),
    .pkg_d    (pkg_d),
    .pkg_vld  (pkg_vld),
    .pkg_done (pkg_done),
    .sched_err(sched_err),
    .err_clr  (err_clr)
  );

  always #5 clk_sys = ~clk_sys;

  // Every word the scheduler emits, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (pkg_vld === 1'b1) obs_q.push_back(pkg_d);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_reset();
    rst_n    = 1'b0;
    chip_req = 4'b0;
    chip_vld = 1'b0;
    chip_d   = 16'h0;
    pkg_done = 1'b0;
    err_clr  = 1'b0;
    pluse_us = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic expect_header(input int win);
    logic [1:0] w2;
    w2 = 2'(win);
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({4'hA, dev_id, 4'h0, w2});
  endtask

  task automatic compare_stream(input string tag);
    int bad;
    bad = -1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL %s stream length: got %0d words, expected %0d", tag, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("[TB] FAIL %s stream word %0d: got %h expected %h", tag, bad, obs_q[bad], exp_q[bad]);
      end
    end
  endtask

  // Runs one full packet; the winner comes from the round-robin rule applied to req and m_ptr.
  task automatic send_packet(input logic [3:0] req, input int vld_mode, input bit fixed_data,
                             input bit drop_req, input bit done_noise, input string tag,
                             output logic [3:0] got_gnt);
    int          win;
    int          k;
    int          guard;
    bit          prev_acc;
    logic [15:0] prev_w;
    logic [3:0]  exp_gnt;
    win = -1;
    for (int i = 0; i < 4; i++) if (win < 0 && req[(m_ptr + i) % 4]) win = (m_ptr + i) % 4;
    exp_gnt = 4'b0001 << win;
    expect_header(win);
    chip_req = req;
    guard = 0;
    while (chip_gnt === 4'b0 && guard < 20) begin
      @(posedge clk_sys); #1; guard++;
    end
    got_gnt = chip_gnt;
    checks++;
    if (chip_gnt !== exp_gnt) begin
      errors++;
      $display("[TB] FAIL %s grant: got %b expected %b", tag, chip_gnt, exp_gnt);
    end
    if (drop_req) chip_req = 4'b0;
    k = 0; guard = 0; prev_acc = 0; prev_w = 16'h0;
    while (k < PKT_LEN && guard < 500) begin
      if (prev_acc) begin
        checks++;
        if (pkg_vld !== 1'b1 || pkg_d !== prev_w) begin
          errors++;
          $display("[TB] FAIL %s word latency: got vld=%b d=%h expected vld=1 d=%h", tag, pkg_vld, pkg_d, prev_w);
        end
      end
      case (vld_mode)
        0:       chip_vld = 1'b1;
        1:       chip_vld = (guard % 3 == 0);
        default: chip_vld = 1'($urandom_range(0, 1));
      endcase
      chip_d   = fixed_data ? 16'(k + 1) : 16'($urandom);
      pkg_done = done_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_acc = chip_vld && chip_rdy;
      prev_w   = chip_d;
      if (prev_acc) begin
        exp_q.push_back(chip_d);
        k++;
      end
      @(posedge clk_sys); #1; guard++;
    end
    chip_vld = 1'b0;
    pkg_done = 1'b0;
    checks++;
    if (pkg_vld !== 1'b1 || pkg_d !== prev_w || chip_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s last word: got vld=%b d=%h rdy=%b expected vld=1 d=%h rdy=0",
               tag, pkg_vld, pkg_d, chip_rdy, prev_w);
    end
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if (pkg_vld !== 1'b0 || chip_gnt !== exp_gnt) begin
      errors++;
      $display("[TB] FAIL %s wait_done: got vld=%b gnt=%b expected vld=0 gnt=%b", tag, pkg_vld, chip_gnt, exp_gnt);
    end
    pkg_done = 1'b1;
    @(posedge clk_sys); #1;
    pkg_done = 1'b0;
    checks++;
    if (chip_gnt !== 4'b0) begin
      errors++;
      $display("[TB] FAIL %s grant release: got %b expected 0000", tag, chip_gnt);
    end
    compare_stream(tag);
    m_ptr = (win + 1) % 4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if ({chip_gnt, chip_rdy, pkg_d, pkg_vld, sched_err} !== 23'b0) begin
      errors++;
      $display("[TB] FAIL reset outputs: got gnt=%b rdy=%b d=%h vld=%b err=%b expected all zero",
               chip_gnt, chip_rdy, pkg_d, pkg_vld, sched_err);
    end
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_single();
    logic [3:0] g;
    dev_id = 6'h15;
    send_packet(4'b0010, 0, 1'b1, 1'b0, 1'b0, "single", g);
    checks++;
    if (obs_q.size() == 0 || obs_q[0] !== 16'hA541) begin
      errors++;
      $display("[TB] FAIL single header: got %h expected a541", obs_q.size() ? obs_q[0] : 16'h0);
    end
    chip_req = 4'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    apply_reset();
    dev_id = 6'h2A;
    for (int n = 0; n < 5; n++) begin
      send_packet(4'b1111, 0, 1'b0, 1'b0, 1'b0, "round_robin", g);
      checks++;
      if (g !== 4'(1 << (n % 4))) begin
        errors++;
        $display("[TB] FAIL round_robin order %0d: got %b expected %b", n, g, 4'(1 << (n % 4)));
      end
    end
    chip_req = 4'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] g;
    apply_reset();
    for (int n = 0; n < 2; n++) begin
      dev_id = 6'($urandom);
      send_packet(4'b0100 | 4'(n), 1, 1'b0, 1'b0, 1'b0, "backpressure", g);
    end
    chip_req = 4'b0;
  endtask

  task automatic test_random();
    logic [3:0] g;
    apply_reset();
    for (int n = 0; n < 10; n++) begin
      dev_id = 6'($urandom);
      send_packet(4'($urandom_range(1, 15)), 2, 1'b0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), "random", g);
    end
    chip_req = 4'b0;
  endtask

  task automatic test_done_ignored();
    logic [3:0] g;
    apply_reset();
    dev_id = 6'h07;
    send_packet(4'b1000, 0, 1'b0, 1'b1, 1'b1, "done_ignored", g);
    chip_req = 4'b0;
  endtask

  // Source 0 stalls after five words; with the timeout enabled the rest is padded with FFFF.
  task automatic test_timeout(input bit hold_clr);
    int k;
    int guard;
    apply_reset();
    dev_id = 6'h3C;
    expect_header(0);
    chip_req = 4'b0001;
    err_clr  = hold_clr;
    guard = 0;
    while (chip_gnt === 4'b0 && guard < 20) begin
      @(posedge clk_sys); #1; guard++;
    end
    k = 0; guard = 0;
    while (k < 5 && guard < 50) begin
      chip_vld = 1'b1;
      chip_d   = 16'($urandom);
      if (chip_rdy) begin
        exp_q.push_back(chip_d);
        k++;
      end
      @(posedge clk_sys); #1; guard++;
    end
    chip_vld = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pluse_us = 1'b1;
      @(posedge clk_sys); #1;
      pluse_us = 1'b0;
`ifdef PKG_SCHED_TIMEOUT_EN
      if (p == 2) begin
        checks++;
        if (sched_err !== 1'b1 || chip_rdy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL timeout hit: got err=%b rdy=%b expected err=1 rdy=0", sched_err, chip_rdy);
        end
      end
`endif
      @(posedge clk_sys); #1;
    end
    err_clr = 1'b0;
`ifdef PKG_SCHED_TIMEOUT_EN
    for (int i = k; i < PKT_LEN; i++) exp_q.push_back(16'hFFFF);
    repeat (PKT_LEN) @(posedge clk_sys);
    #1;
    checks++;
    if (sched_err !== !hold_clr || pkg_vld !== 1'b0 || chip_gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL timeout wait_done: got err=%b vld=%b gnt=%b expected err=%b vld=0 gnt=0001",
               sched_err, pkg_vld, chip_gnt, !hold_clr);
    end
`else
    checks++;
    if (sched_err !== 1'b0 || chip_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_timeout stall: got err=%b rdy=%b expected err=0 rdy=1", sched_err, chip_rdy);
    end
    guard = 0;
    while (k < PKT_LEN && guard < 50) begin
      chip_vld = 1'b1;
      chip_d   = 16'($urandom);
      if (chip_rdy) begin
        exp_q.push_back(chip_d);
        k++;
      end
      @(posedge clk_sys); #1; guard++;
    end
    chip_vld = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
`endif
    chip_req = 4'b0;
    pkg_done = 1'b1;
    @(posedge clk_sys); #1;
    pkg_done = 1'b0;
    err_clr  = 1'b1;
    @(posedge clk_sys); #1;
    err_clr  = 1'b0;
    checks++;
    if (sched_err !== 1'b0 || chip_gnt !== 4'b0) begin
      errors++;
      $display("[TB] FAIL timeout clear: got err=%b gnt=%b expected err=0 gnt=0000", sched_err, chip_gnt);
    end
    compare_stream(hold_clr ? "timeout_clr_held" : "timeout");
  endtask

  task automatic test_reset_mid();
    int         k;
    int         guard;
    logic [3:0] g;
    apply_reset();
    chip_req = 4'b0110;
    for (int n = 0; n < 2; n++) send_packet(chip_req, 0, 1'b0, 1'b0, 1'b0, "pre_reset", g);
    chip_req = 4'b0100;
    guard = 0;
    while (chip_gnt === 4'b0 && guard < 20) begin
      @(posedge clk_sys); #1; guard++;
    end
    k = 0; guard = 0;
    while (k < 4 && guard < 50) begin
      chip_vld = 1'b1;
      chip_d   = 16'($urandom);
      if (chip_rdy) k++;
      @(posedge clk_sys); #1; guard++;
    end
    rst_n    = 1'b0;
    chip_vld = 1'b0;
    chip_req = 4'b0;
    @(posedge clk_sys); #1;
    checks++;
    if ({chip_gnt, chip_rdy, pkg_d, pkg_vld, sched_err} !== 23'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid outputs: got gnt=%b rdy=%b d=%h vld=%b err=%b expected all zero",
               chip_gnt, chip_rdy, pkg_d, pkg_vld, sched_err);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    obs_q.delete();
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid leftover words: got %0d expected 0", obs_q.size());
    end
    send_packet(4'b1111, 0, 1'b0, 1'b0, 1'b0, "post_reset", g);
    checks++;
    if (g !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL post_reset pointer: got %b expected 0001", g);
    end
    chip_req = 4'b0;
  endtask

  initial begin
    dev_id = 6'h0;
    apply_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_random();
    test_done_ignored();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkg_sched.md
PKG_SCHED -- requirements
Module: pkg_sched

Interface
- REQ-001 SHALL have parameter PKT_LEN, default 8: payload words per packet, legal range 1..63.
- REQ-002 SHALL have parameter TIMEOUT_US, default 100: microseconds without a word before a packet is aborted, legal range 1..255.
- REQ-003 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic is on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-005 SHALL have port pluse_us, input, 1 bit: one-cycle pulse once per microsecond.
- REQ-006 SHALL have port dev_id, input, 6 bits: device ID inserted into each header.
- REQ-007 SHALL have port chip_req, input, 4 bits: per-source packet request, level-sensitive.
- REQ-008 SHALL have port chip_gnt, output, 4 bits: one-hot grant to the selected source.
- REQ-009 SHALL have port chip_d, input, 16 bits: payload word from the granted source.
- REQ-010 SHALL have port chip_vld, input, 1 bit: chip_d is valid this cycle.
- REQ-011 SHALL have port chip_rdy, output, 1 bit: scheduler accepts a word this cycle.
- REQ-012 SHALL have port pkg_d, output, 16 bits: packet word to the packer.
- REQ-013 SHALL have port pkg_vld, output, 1 bit: one-cycle qualifier for pkg_d.
- REQ-014 SHALL have port pkg_done, input, 1 bit: pulse from the packer when the packet has been consumed.
- REQ-015 SHALL have port sched_err, output, 1 bit: sticky timeout flag.
- REQ-016 SHALL have port err_clr, input, 1 bit: clears sched_err.

Function
- REQ-017 SHALL use FSM states IDLE, HDR, DATA and WAIT_DONE.
- REQ-018 IDLE: SHALL stay in IDLE while chip_req is 0.
- REQ-019 IDLE: when any chip_req bit is set, SHALL pick the winner by round-robin, starting after the last winner, and go to HDR.
- REQ-020 After reset, source 0 SHALL have the highest priority.
- REQ-021 HDR: SHALL assert chip_gnt one-hot for the winner from HDR entry until WAIT_DONE exit.
- REQ-022 HDR: SHALL output pkg_d = {4'hA, dev_id, 4'h0, ch[1:0]} with pkg_vld=1 for exactly one cycle, then go to DATA.
- REQ-023 DATA: chip_rdy SHALL be 1 only in DATA.
- REQ-024 DATA: each cycle with chip_vld&&chip_rdy SHALL register chip_d onto pkg_d with pkg_vld=1 on the next cycle (latency 1) and increment a 6-bit word counter.
- REQ-025 DATA: after word PKT_LEN is accepted, SHALL deassert chip_rdy on the next cycle and go to WAIT_DONE.
- REQ-026 chip_vld SHALL be ignored outside DATA and when chip_rdy is 0.
- REQ-027 WAIT_DONE: on pkg_done, SHALL drop chip_gnt, update the round-robin pointer and return to IDLE.
- REQ-028 pkg_done SHALL be ignored in every other state.
- REQ-029 A source that deasserts chip_req mid-packet SHALL NOT end the packet early.
- REQ-030 A request arriving while the scheduler is busy SHALL wait for the next IDLE arbitration.
- REQ-031 If pkg_done and a new request occur in the same cycle, the FSM SHALL return to IDLE first; the next grant comes no earlier than the cycle after.
- REQ-032 If err_clr and a new error occur in the same cycle, the error SHALL win and sched_err stays 1.
- REQ-033 pkg_vld SHALL be 0 in IDLE and WAIT_DONE, and SHALL never exceed PKT_LEN+1 pulses per grant.

Reset
- REQ-034 While rst_n=0 at a clock edge: state=IDLE, chip_gnt=0, chip_rdy=0, pkg_d=0, pkg_vld=0, sched_err=0, word counter=0, timeout counter=0, round-robin pointer=source 0.
- REQ-035 Reset asserted mid-packet SHALL abort the packet with no further pkg_vld.

Configuration
- REQ-036 Macro PKG_SCHED_TIMEOUT_EN defined: in DATA, SHALL count pluse_us pulses since the last accepted word and reset the count on each accepted word.
- REQ-037 With PKG_SCHED_TIMEOUT_EN, when the count reaches TIMEOUT_US, SHALL set sched_err, drop chip_rdy, and emit the remaining words as 16'hFFFF at one per cycle, then go to WAIT_DONE.
- REQ-038 Macro PKG_SCHED_TIMEOUT_EN undefined: SHALL have no timeout logic, DATA waits indefinitely, and sched_err SHALL be constant 0.

Verification
- REQ-039 Single request: chip_req=4'b0010, dev_id=6'h15, 8 words 16'h0001..0008 -> header 16'hA541, then 8 words in order, each one cycle after acceptance; chip_gnt=4'b0010 until pkg_done.
- REQ-040 Round-robin: chip_req=4'b1111 held for 4 packets -> grant order 0,1,2,3; a fifth packet goes to source 0.
- REQ-041 Backpressure: chip_vld toggled every third cycle -> exactly 8 pkg_vld payload pulses, no duplicates or drops; chip_rdy=0 after word 8.
- REQ-042 Timeout (macro on, TIMEOUT_US=3): source stops after 5 words, 3 pluse_us pulses -> sched_err=1, 3 words of 16'hFFFF, then WAIT_DONE; err_clr -> sched_err=0.
- REQ-043 Reset mid-DATA after word 4 (rst_n=0 for one cycle) -> all outputs 0 next cycle, state IDLE, pointer reset to source 0.
- REQ-044 pkg_done in HDR or DATA -> ignored, and the packet completes normally.
